mem_req_ctrl: RTL and testbench



---
 rtl/mem_req_pkg.sv | 8 +
 rtl/mem_rsp_fifo.sv | 54 +++++
 rtl/mem_req_ctrl.sv | 110 +++++++++++
 tb/tb_mem_req_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_req_pkg.sv
// Shared defaults and state encoding for the RAM request front end.
package mem_req_pkg;
    localparam int unsigned ADDR_W_DEF    = 4;
    localparam int unsigned DATA_W_DEF    = 8;
    localparam int unsigned RSP_DEPTH_DEF = 4;

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;
endpackage

// File: rtl/mem_rsp_fifo.sv
// Response FIFO: synchronous push/pop with occupancy count; output holds the
// last popped word while empty.
module mem_rsp_fifo
    import mem_req_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = RSP_DEPTH_DEF,
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned CW    = PW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_dat,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_dat,
    output logic [CW-1:0]     count
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [DATA_W-1:0] last_dat;
    logic              pop_ok;

    assign pop_ok  = pop && (count != '0);
    assign pop_dat = (count != '0) ? mem[rd_ptr] : last_dat;

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            last_dat <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr   <= rd_ptr + 1'b1;
                last_dat <= mem[rd_ptr];
            end
            count <= count + CW'(push) - CW'(pop_ok);
        end
    end

    assert property (@(posedge clk) disable iff (rst) push |-> (count < CW'(DEPTH)));
endmodule

// File: rtl/mem_req_ctrl.sv
// Valid/ready command front end for a synchronous-read RAM with in-order read
// responses. Define MEM_REQ_CLEAR_EN to zero the RAM after every reset.
module mem_req_ctrl
    import mem_req_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned RSP_DEPTH = RSP_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_adr,
    input  logic [DATA_W-1:0] req_dat,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_dat,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_dat_w,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_dat_r,
    output logic              busy
);
    localparam int unsigned CW  = $clog2(RSP_DEPTH) + 1;
    localparam int unsigned CW1 = CW + 1;

    state_t            state;
    logic              ready_en;
    logic              rd_pend;
    logic [ADDR_W-1:0] hold_adr;
    logic [CW-1:0]     count;
    logic [CW1-1:0]    credit;
    logic              accept;
    logic              pop;
    logic              clearing;

`ifdef MEM_REQ_CLEAR_EN
    localparam state_t RST_STATE = ST_CLEAR;
    logic [ADDR_W-1:0] clr_adr;
    assign clearing = !rst && ready_en && (state == ST_CLEAR);
    assign busy     = rst || rd_pend || (count != '0) || (state == ST_CLEAR);
`else
    localparam state_t RST_STATE = ST_RUN;
    assign clearing = 1'b0;
    assign busy     = !rst && (rd_pend || (count != '0));
`endif

    assign rsp_valid = !rst && (count != '0);
    assign pop       = rsp_valid && rsp_ready;

    // Credit counts words already queued plus the read whose data lands this
    // cycle, so an accepted read always finds a free FIFO slot.
    assign credit    = {1'b0, count} + CW1'(rd_pend) - CW1'(pop);
    assign req_ready = !rst && ready_en && (state == ST_RUN) && (credit < CW1'(RSP_DEPTH));
    assign accept    = req_valid && req_ready;

    always_comb begin
        mem_adr   = accept ? req_adr : hold_adr;
        mem_dat_w = req_dat;
        mem_we    = accept && req_we;
`ifdef MEM_REQ_CLEAR_EN
        if (clearing) begin
            mem_adr   = clr_adr;
            mem_dat_w = '0;
            mem_we    = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RST_STATE;
            ready_en <= 1'b0;
            rd_pend  <= 1'b0;
            hold_adr <= '0;
`ifdef MEM_REQ_CLEAR_EN
            clr_adr  <= '0;
`endif
        end else begin
            ready_en <= 1'b1;
            rd_pend  <= accept && !req_we;
            if (accept) begin
                hold_adr <= req_adr;
            end
`ifdef MEM_REQ_CLEAR_EN
            if (clearing) begin
                clr_adr <= clr_adr + 1'b1;
                if (clr_adr == '1) begin
                    state <= ST_RUN;
                end
            end
`endif
        end
    end

    mem_rsp_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (rd_pend),
        .push_dat (mem_dat_r),
        .pop      (pop),
        .pop_dat  (rsp_dat),
        .count    (count)
    );
endmodule

// File: tb/tb_mem_req_ctrl.sv
// Scoreboard bench for mem_req_ctrl with a behavioural 16x8 synchronous-read RAM.
module tb_mem_req_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [3:0] req_adr;
    logic [7:0] req_dat;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_dat;
    logic [3:0] mem_adr;
    logic [7:0] mem_dat_w;
    logic       mem_we;
    logic [7:0] mem_dat_r;
    logic       busy;

    always #5 clk = ~clk;

    mem_req_ctrl #(
        .ADDR_W    (4),
        .DATA_W    (8),
        .RSP_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_adr   (req_adr),
        .req_dat   (req_dat),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dat   (rsp_dat),
        .mem_adr   (mem_adr),
        .mem_dat_w (mem_dat_w),
        .mem_we    (mem_we),
        .mem_dat_r (mem_dat_r),
        .busy      (busy)
    );

    function automatic logic [7:0] init_val(input int unsigned a);
        case (a)
            0: init_val = 8'h90;  1: init_val = 8'hB3;  2: init_val = 8'h23;  3: init_val = 8'hFE;
            4: init_val = 8'hA7;  5: init_val = 8'h4F;  6: init_val = 8'h11;  7: init_val = 8'h22;
            8: init_val = 8'h33;  9: init_val = 8'h44; 10: init_val = 8'h55; 11: init_val = 8'h66;
            12: init_val = 8'h77; 13: init_val = 8'h88; 14: init_val = 8'h99; default: init_val = 8'hAA;
        endcase
    endfunction

    logic [7:0] ram [16];
    logic [3:0] ram_adr_q;
    logic       ram_loaded = 1'b0;

    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 16; i++) ram[i] <= init_val(i);
            ram_loaded <= 1'b1;
        end else if (mem_we) begin
            ram[mem_adr] <= mem_dat_w;
        end
        ram_adr_q <= mem_adr;
    end
    assign mem_dat_r = ram[ram_adr_q];

    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         rsp_seen = 0;
    int         last_rsp_cyc = 0;
    int         last_acc_cyc = 0;
    logic [7:0] exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rsp_valid && rsp_ready) begin
            logic [7:0] e;
            tests++;
            rsp_seen++;
            last_rsp_cyc = cyc;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL rsp_unexpected: got %02h, required no response", rsp_dat);
            end else begin
                e = exp_q.pop_front();
                if (rsp_dat !== e) begin
                    fails++;
                    $display("FAIL rsp_dat: got %02h, required %02h", rsp_dat, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic we, input logic [3:0] adr, input logic [7:0] dat,
                        input logic [7:0] exp, output int waits);
        req_valid = 1'b1;
        req_we    = we;
        req_adr   = adr;
        req_dat   = dat;
        waits     = 0;
        @(negedge clk);
        while (!req_ready && waits < 100) begin
            waits++;
            @(negedge clk);
        end
        if (!req_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: req_ready stayed 0 for adr %0h, required 1", adr);
        end else begin
            check("acc_mem_we", mem_we, we);
            check("acc_mem_adr", mem_adr, adr);
            last_acc_cyc = cyc;
            if (!we) exp_q.push_back(exp);
        end
        tick();
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("drain_left", exp_q.size(), 0);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int k0;
        int s0;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_adr = '0; req_dat = '0; rsp_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_mem_we", mem_we, 0);
`ifdef MEM_REQ_CLEAR_EN
        check("rst_busy", busy, 1);
`else
        check("rst_busy", busy, 0);
`endif
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_req_ready", req_ready, 0);
        check("post_rst_rsp_valid", rsp_valid, 0);
        check("post_rst_mem_we", mem_we, 0);
`ifdef MEM_REQ_CLEAR_EN
        check("post_rst_busy", busy, 1);
        tick();
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check("clr_mem_we", mem_we, 1);
            check("clr_mem_adr", mem_adr, k);
            check("clr_dat_w", mem_dat_w, 0);
            check("clr_req_ready", req_ready, 0);
            check("clr_busy", busy, 1);
            tick();
        end
        send(1'b0, 4'd3, 8'h00, 8'h00, w);
        check("clr_read_wait", w, 0);
        drain();
`else
        check("post_rst_busy", busy, 0);
        tick();

        // single read: response exactly two cycles after accept
        send(1'b0, 4'd3, 8'h00, 8'hFE, w);
        @(negedge clk);
        check("rd_n1_valid", rsp_valid, 0);
        check("rd_n1_busy", busy, 1);
        @(negedge clk);
        check("rd_n2_valid", rsp_valid, 1);
        @(negedge clk);
        #1;
        check("rd_n3_valid", rsp_valid, 0);
        check("rd_n3_busy", busy, 0);
        check("rd_latency", last_rsp_cyc - last_acc_cyc, 2);
        tick();

        // backpressure: four credits, then stall until consumer drains
        rsp_ready = 1'b0;
        for (int a = 0; a < 4; a++) begin
            send(1'b0, 4'(a), 8'h00, init_val(a), w);
            check("bp_accept_wait", w, 0);
        end
        req_valid = 1'b1; req_we = 1'b0; req_adr = 4'd4;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_req_ready", req_ready, 0);
            check("bp_rsp_valid", rsp_valid, 1);
            tick();
        end
        rsp_ready = 1'b1;
        send(1'b0, 4'd4, 8'h00, 8'hA7, w);
        check("bp_resume_wait", w, 0);
        send(1'b0, 4'd5, 8'h00, 8'h4F, w);
        drain();

        // streaming: 16 back-to-back reads, responses one per cycle
        s0 = rsp_seen;
        send(1'b0, 4'd0, 8'h00, init_val(0), w);
        k0 = last_acc_cyc;
        check("st_wait", w, 0);
        for (int a = 1; a < 16; a++) begin
            send(1'b0, 4'(a), 8'h00, init_val(a), w);
            check("st_wait", w, 0);
        end
        drain();
        check("st_count", rsp_seen - s0, 16);
        check("st_span", last_rsp_cyc - k0, 17);

        // reset with three responses pending
        rsp_ready = 1'b0;
        send(1'b0, 4'd6, 8'h00, 8'h11, w);
        send(1'b0, 4'd7, 8'h00, 8'h22, w);
        send(1'b0, 4'd8, 8'h00, 8'h33, w);
        tick();
        tick();
        rst = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_adr = 4'd1; req_dat = 8'h5A;
        exp_q.delete();
        @(negedge clk);
        check("mid_rst_mem_we", mem_we, 0);
        check("mid_rst_req_ready", req_ready, 0);
        tick();
        rst = 1'b0;
        req_valid = 1'b0; req_we = 1'b0;
        @(negedge clk);
        check("mid_post_rsp_valid", rsp_valid, 0);
        check("mid_post_busy", busy, 0);
        check("mid_post_req_ready", req_ready, 0);
        tick();
        rsp_ready = 1'b1;
        send(1'b0, 4'd1, 8'h00, 8'hB3, w);
        drain();

        // write then read of the same address on consecutive cycles
        send(1'b1, 4'd5, 8'hA5, 8'h00, w);
        send(1'b0, 4'd5, 8'h00, 8'hA5, w);
        drain();
        check("wr_rd_latency", last_rsp_cyc - last_acc_cyc, 2);
        @(negedge clk);
        check("end_rsp_valid", rsp_valid, 0);
        check("end_busy", busy, 0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
